controle_chamadas: RTL and testbench
====================================

Name: controle_chamadas

Overview:
- Call scheduler for the elevator; replaces the manual up/down switch as the source of movement decisions.
- Latches floor-call buttons and runs a SCAN policy: keep the current direction while calls remain ahead, otherwise reverse.
- Times floor-to-floor travel and door dwell.
- Outputs the current floor on the same 2-bit encoding that feeds display_andar.

Parameters:
- N_ANDARES, 4, number of floors (floor indices 0..N_ANDARES-1).
- LARGURA_ANDAR, 2, width of the floor index; must satisfy 2**LARGURA_ANDAR >= N_ANDARES.
- TICKS_VIAGEM, 4, passo ticks to travel one floor.
- TICKS_PORTA, 6, passo ticks the door stays open.

Ports:
- clock_in  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- passo  input  1  one-cycle timing strobe from the frequency divider; the timers advance only when passo=1.
- botoes  input  N_ANDARES  call buttons, level-sensitive, one bit per floor.
- andar_atual  output  LARGURA_ANDAR  current floor; goes directly to display_andar.
- subindo  output  1  direction of the last or current travel (1 = up).
- em_movimento  output  1  high while in state MOVENDO.
- porta_aberta  output  1  high while in state PORTA.
- pendentes  output  N_ANDARES  latched, unserved calls.

Behaviour:
- Reset (async, reset_n=0):
  - state=OCIOSO, andar_atual=0, subindo=1, pendentes=0, timer=0.
  - All outputs take these values immediately. Reset during motion or door-open abandons the operation.
- Call latching, every clock:
  - pendentes[i] <= pendentes[i] | botoes[i].
  - Exception: a press at andar_atual while porta_aberta=1 does not set the bit. It reloads the door timer to TICKS_PORTA instead.
  - The bit for andar_atual clears on the clock where the state enters PORTA.
- Helper signals, combinational from pendentes and andar_atual:
  - acima = any pending bit above andar_atual.
  - abaixo = any pending bit below andar_atual.
  - aqui = pendentes[andar_atual].
- State OCIOSO:
  - aqui (or botoes[andar_atual]) -> PORTA, timer=TICKS_PORTA.
  - Else if (subindo & acima) or (!subindo & abaixo) -> MOVENDO in the same direction.
  - Else if acima -> subindo=1, MOVENDO.
  - Else if abaixo -> subindo=0, MOVENDO.
  - Else stay in OCIOSO.
  - Transition latency: 1 clock after the call is visible.
  - On entering MOVENDO, timer=TICKS_VIAGEM.
- State MOVENDO:
  - The timer decrements on each passo.
  - When timer==1 and passo=1: andar_atual +/-1 according to subindo.
  - Then, evaluated with the new floor:
    - new floor pending -> PORTA, timer=TICKS_PORTA, bit cleared.
    - else calls remain ahead -> stay in MOVENDO, timer reloads.
    - else -> OCIOSO.
  - Saturation: never step below 0 or above N_ANDARES-1. If a step would leave the range, go to OCIOSO with no step. This is unreachable under SCAN and is an assertion target.
  - Direction never changes inside MOVENDO.
- State PORTA:
  - The timer decrements on passo.
  - When timer==1 and passo=1 -> OCIOSO, which then re-decides the direction on the next clock.
- Simultaneous events:
  - Button and clear on the same floor in the same clock: the clear wins.
  - Multiple buttons in one clock: all are latched.
  - passo=0 freezes all timers but not call latching.
- Timing:
  - Motion per floor = TICKS_VIAGEM passo periods.
  - With no requests, outputs are stable indefinitely.

Decomposition:
- Package elevador_pkg:
  - state enum {OCIOSO, MOVENDO, PORTA}.
  - SUBIR/DESCER constants.
  - Default N_ANDARES and LARGURA_ANDAR.
- One natural sub-module, temporizador_passo:
  - Loadable down-counter advanced by passo.
  - Inputs: carregar, valor.
  - Output: fim, high when count==1 and passo=1.
  - Shared by travel and door timing.
- The remainder is a single FSM plus the pending-call register.

Test Plan:
- Reset mid-travel:
  - Stimulus: reset_n low while em_movimento=1 at floor 2.
  - Required: andar_atual=0, pendentes=0, em_movimento=0, porta_aberta=0 immediately, before any clock edge.
- Single call from idle at floor 0:
  - Stimulus: pulse botoes=4'b1000, passo every 4 clocks.
  - Required: em_movimento=1 on the next clock; andar_atual steps 1, 2, 3, each after 4 passo ticks; porta_aberta=1 at floor 3; pendentes=0.
  - Then, after 6 passo ticks: OCIOSO.
- SCAN ordering:
  - Stimulus: at floor 1 moving up, calls on floors 0 and 3.
  - Required: serves 3 first, then reverses (subindo=0) and serves 0. Never visits 0 before 3.
- Call at current floor:
  - Stimulus: idle at floor 2, botoes[2]=1.
  - Required: porta_aberta=1 next clock, pendentes[2]=0.
  - Stimulus: press floor 2 again while the door is open.
  - Required: dwell extends to 6 ticks from the re-press; bit stays 0.
- passo held low:
  - Stimulus: call on floor 3 from 0, passo=0 for 100 clocks.
  - Required: andar_atual stays 0, em_movimento=1, pendentes[3]=1.
- Buttons during travel:
  - Stimulus: moving up 0->3, press floor 2 before reaching floor 2.
  - Required: stops at 2 (door opens), then continues to 3.
  - Stimulus: press floor 0 during the same travel.
  - Required: served only after 3.

Source files
------------

// File: rtl/elevador_pkg.sv
// Shared types and defaults for the elevator call scheduler.
package elevador_pkg;

    localparam int unsigned N_ANDARES_PADRAO     = 4;
    localparam int unsigned LARGURA_ANDAR_PADRAO = 2;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        MOVENDO = 2'd1,
        PORTA   = 2'd2
    } estado_t;

    localparam logic SUBIR  = 1'b1;
    localparam logic DESCER = 1'b0;

endpackage

// File: rtl/temporizador_passo.sv
// Loadable down-counter advanced by the passo strobe; fim_c marks the last tick.
module temporizador_passo #(
    parameter int unsigned LARGURA = 3
) (
    input  logic               clock_in,
    input  logic               reset_n,
    input  logic               passo,
    input  logic               carregar,
    input  logic [LARGURA-1:0] valor,
    output logic               fim_c
);

    logic [LARGURA-1:0] contagem;

    assign fim_c = passo && (contagem == LARGURA'(1));

    // A load always wins over a tick on the same clock.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            contagem <= '0;
        end else if (carregar) begin
            contagem <= valor;
        end else if (passo && (contagem != '0)) begin
            contagem <= contagem - LARGURA'(1);
        end
    end

endmodule

// File: rtl/controle_chamadas.sv
// SCAN call scheduler: latches floor calls, picks travel direction and times
// floor-to-floor travel and door dwell.
module controle_chamadas
    import elevador_pkg::*;
#(
    parameter int unsigned N_ANDARES     = N_ANDARES_PADRAO,
    parameter int unsigned LARGURA_ANDAR = LARGURA_ANDAR_PADRAO,
    parameter int unsigned TICKS_VIAGEM  = 4,
    parameter int unsigned TICKS_PORTA   = 6
) (
    input  logic                     clock_in,
    input  logic                     reset_n,
    input  logic                     passo,
    input  logic [N_ANDARES-1:0]     botoes,
    output logic [LARGURA_ANDAR-1:0] andar_atual,
    output logic                     subindo,
    output logic                     em_movimento,
    output logic                     porta_aberta,
    output logic [N_ANDARES-1:0]     pendentes
);

    localparam int unsigned TICKS_MAX     = (TICKS_VIAGEM > TICKS_PORTA) ? TICKS_VIAGEM : TICKS_PORTA;
    localparam int unsigned LARGURA_TIMER = $clog2(TICKS_MAX + 1);

    estado_t                  estado, estado_prox;
    logic [LARGURA_ANDAR-1:0] andar_prox, andar_passo;
    logic                     subindo_prox;
    logic [N_ANDARES-1:0]     pend_prox, chamadas, limpar, botoes_uteis;
    logic                     acima, abaixo, aqui, alem_passo, sai_faixa;
    logic                     carregar, fim_c;
    logic [LARGURA_TIMER-1:0] valor;

    temporizador_passo #(
        .LARGURA (LARGURA_TIMER)
    ) u_temporizador (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .passo    (passo),
        .carregar (carregar),
        .valor    (valor),
        .fim_c    (fim_c)
    );

    // Next-state, next-floor and call-register logic.
    always_comb begin
        estado_prox  = estado;
        andar_prox   = andar_atual;
        subindo_prox = subindo;
        carregar     = 1'b0;
        valor        = '0;
        limpar       = '0;
        botoes_uteis = botoes;
        chamadas     = pendentes | botoes;
        acima        = 1'b0;
        abaixo       = 1'b0;
        alem_passo   = 1'b0;
        aqui         = chamadas[andar_atual];

        if (subindo) begin
            andar_passo = andar_atual + LARGURA_ANDAR'(1);
            sai_faixa   = (int'(andar_atual) == int'(N_ANDARES) - 1);
        end else begin
            andar_passo = andar_atual - LARGURA_ANDAR'(1);
            sai_faixa   = (andar_atual == '0);
        end

        for (int i = 0; i < int'(N_ANDARES); i++) begin
            if (i > int'(andar_atual)) acima  = acima  | chamadas[i];
            if (i < int'(andar_atual)) abaixo = abaixo | chamadas[i];
            if (subindo ? (i > int'(andar_passo)) : (i < int'(andar_passo)))
                alem_passo = alem_passo | chamadas[i];
        end

        case (estado)
            OCIOSO: begin
                if (aqui) begin
                    estado_prox          = PORTA;
                    carregar             = 1'b1;
                    valor                = LARGURA_TIMER'(TICKS_PORTA);
                    limpar[andar_atual]  = 1'b1;
                end else if ((subindo && acima) || (!subindo && abaixo)) begin
                    estado_prox = MOVENDO;
                    carregar    = 1'b1;
                    valor       = LARGURA_TIMER'(TICKS_VIAGEM);
                end else if (acima || abaixo) begin
                    subindo_prox = acima ? SUBIR : DESCER;
                    estado_prox  = MOVENDO;
                    carregar     = 1'b1;
                    valor        = LARGURA_TIMER'(TICKS_VIAGEM);
                end
            end
            MOVENDO: begin
                if (fim_c) begin
                    if (sai_faixa) begin
                        estado_prox = OCIOSO;
                    end else begin
                        andar_prox = andar_passo;
                        if (chamadas[andar_passo]) begin
                            estado_prox         = PORTA;
                            carregar            = 1'b1;
                            valor               = LARGURA_TIMER'(TICKS_PORTA);
                            limpar[andar_passo] = 1'b1;
                        end else if (alem_passo) begin
                            carregar = 1'b1;
                            valor    = LARGURA_TIMER'(TICKS_VIAGEM);
                        end else begin
                            estado_prox = OCIOSO;
                        end
                    end
                end
            end
            PORTA: begin
                // A re-press at the open floor extends the dwell instead of queuing a call.
                if (botoes[andar_atual]) begin
                    botoes_uteis[andar_atual] = 1'b0;
                    carregar                  = 1'b1;
                    valor                     = LARGURA_TIMER'(TICKS_PORTA);
                end else if (fim_c) begin
                    estado_prox = OCIOSO;
                end
            end
            default: estado_prox = OCIOSO;
        endcase

        pend_prox = (pendentes | botoes_uteis) & ~limpar;
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            estado       <= OCIOSO;
            andar_atual  <= '0;
            subindo      <= SUBIR;
            pendentes    <= '0;
            em_movimento <= 1'b0;
            porta_aberta <= 1'b0;
        end else begin
            estado       <= estado_prox;
            andar_atual  <= andar_prox;
            subindo      <= subindo_prox;
            pendentes    <= pend_prox;
            em_movimento <= (estado_prox == MOVENDO);
            porta_aberta <= (estado_prox == PORTA);
        end
    end

    // SCAN only moves toward a pending call, so a step out of range means a broken invariant.
    assert property (@(posedge clock_in) disable iff (!reset_n)
        !((estado == MOVENDO) && fim_c && sai_faixa));

endmodule

// File: tb/tb_controle_chamadas.sv
// Bench for controle_chamadas: directed scenarios plus random traffic against a behavioural model.
module tb_controle_chamadas;

    localparam int TV = 4;
    localparam int TP = 6;
    localparam int PARADO = 0;
    localparam int ANDANDO = 1;
    localparam int ABERTA = 2;

    logic       clock_in = 1'b0;
    logic       reset_n  = 1'b0;
    logic       passo    = 1'b0;
    logic [3:0] botoes   = 4'b0;
    logic [1:0] andar_atual;
    logic       subindo, em_movimento, porta_aberta;
    logic [3:0] pendentes;

    controle_chamadas dut (
        .clock_in     (clock_in),
        .reset_n      (reset_n),
        .passo        (passo),
        .botoes       (botoes),
        .andar_atual  (andar_atual),
        .subindo      (subindo),
        .em_movimento (em_movimento),
        .porta_aberta (porta_aberta),
        .pendentes    (pendentes)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        int         modo;
        int         andar;
        bit         sobe;
        logic [3:0] pend;
        int         resta;
    } modelo_t;

    modelo_t m;
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  modo_passo = 4;
    int  portas[$];
    logic porta_ant = 1'b0;

    function automatic modelo_t inicial();
        modelo_t r;
        r.modo = PARADO; r.andar = 0; r.sobe = 1'b1; r.pend = 4'b0; r.resta = 0;
        return r;
    endfunction

    function automatic bit tem_alem(logic [3:0] v, int a, bit sobe);
        for (int j = 0; j < 4; j++)
            if (v[j] && (sobe ? (j > a) : (j < a))) return 1'b1;
        return 1'b0;
    endfunction

    // What the scheduler must do next, stated as SCAN rules on floors and calls.
    function automatic modelo_t proximo(modelo_t a, logic [3:0] b, logic p);
        modelo_t n = a;
        logic [3:0] ch = a.pend | b;
        int dest;
        case (a.modo)
            PARADO: begin
                n.pend = ch;
                if (ch[a.andar]) begin
                    n.modo = ABERTA; n.resta = TP; n.pend[a.andar] = 1'b0;
                end else if (tem_alem(ch, a.andar, a.sobe)) begin
                    n.modo = ANDANDO; n.resta = TV;
                end else if (tem_alem(ch, a.andar, !a.sobe)) begin
                    n.sobe = !a.sobe; n.modo = ANDANDO; n.resta = TV;
                end
            end
            ANDANDO: begin
                n.pend = ch;
                if (p) begin
                    if (a.resta > 1) n.resta = a.resta - 1;
                    else begin
                        dest = a.andar + (a.sobe ? 1 : -1);
                        if (dest < 0 || dest > 3) n.modo = PARADO;
                        else begin
                            n.andar = dest;
                            if (ch[dest]) begin
                                n.modo = ABERTA; n.resta = TP; n.pend[dest] = 1'b0;
                            end else if (tem_alem(ch, dest, a.sobe)) n.resta = TV;
                            else n.modo = PARADO;
                        end
                    end
                end
            end
            default: begin
                if (b[a.andar]) begin
                    n.resta = TP;
                    n.pend = a.pend | (b & ~(4'b0001 << a.andar));
                end else begin
                    n.pend = ch;
                    if (p) begin
                        if (a.resta > 1) n.resta = a.resta - 1;
                        else n.modo = PARADO;
                    end
                end
            end
        endcase
        return n;
    endfunction

    always @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) m <= inicial();
        else          m <= proximo(m, botoes, passo);
    end

    // Every-cycle comparison against the model, plus a log of floors where the door opened.
    always @(negedge clock_in) begin
        if (reset_n === 1'b1) begin
            checks = checks + 1;
            if (andar_atual !== 2'(m.andar) || subindo !== m.sobe ||
                em_movimento !== (m.modo == ANDANDO) || porta_aberta !== (m.modo == ABERTA) ||
                pendentes !== m.pend) begin
                failures = failures + 1;
                $display("FAIL modelo t=%0t andar=%0d/%0d sub=%0b/%0b mov=%0b/%0b porta=%0b/%0b pend=%b/%b (got/expected)",
                         $time, andar_atual, m.andar, subindo, m.sobe, em_movimento, m.modo == ANDANDO,
                         porta_aberta, m.modo == ABERTA, pendentes, m.pend);
            end
            if (porta_aberta && !porta_ant) portas.push_back(int'(andar_atual));
            porta_ant = porta_aberta;
        end else begin
            porta_ant = 1'b0;
        end
    end

    task automatic verifica(input string nome, input int atual, input int esperado);
        checks = checks + 1;
        if (atual != esperado) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
        end
    endtask

    task automatic ciclo(input logic [3:0] b);
        botoes = b;
        if (modo_passo > 0)       passo = ((cyc % modo_passo) == (modo_passo - 1));
        else if (modo_passo == 0) passo = 1'b0;
        else                      passo = ($urandom_range(0, 2) == 0);
        cyc = cyc + 1;
        @(posedge clock_in);
        #1;
    endtask

    task automatic ate_andar(input string nome, input int alvo, input int limite);
        int k = 0;
        while (int'(andar_atual) != alvo && k < limite) begin ciclo(4'b0); k++; end
        verifica(nome, int'(andar_atual), alvo);
    endtask

    task automatic ate_ocioso(input string nome, input int limite);
        int k = 0;
        while ((em_movimento || porta_aberta || pendentes != 4'b0) && k < limite) begin
            ciclo(4'b0); k++;
        end
        verifica(nome, int'(em_movimento || porta_aberta || pendentes != 4'b0), 0);
    endtask

    task automatic conta_porta(input string nome);
        int pt = 0;
        int k = 0;
        while (porta_aberta && k < 200) begin
            ciclo(4'b0);
            if (passo) pt++;
            k++;
        end
        verifica(nome, pt, TP);
    endtask

    task automatic reinicia();
        reset_n = 1'b0; botoes = 4'b0; passo = 1'b0;
        repeat (2) @(posedge clock_in);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pt;
        int k;
        logic [3:0] b;

        repeat (2) @(posedge clock_in);
        #1;
        verifica("reset andar", int'(andar_atual), 0);
        verifica("reset subindo", int'(subindo), 1);
        verifica("reset mov", int'(em_movimento), 0);
        verifica("reset porta", int'(porta_aberta), 0);
        verifica("reset pend", int'(pendentes), 0);
        reset_n = 1'b1;

        // Single call from floor 0 to floor 3.
        modo_passo = 4; cyc = 0;
        ciclo(4'b1000);
        verifica("t2 mov next clock", int'(em_movimento), 1);
        verifica("t2 pend latched", int'(pendentes), 8);
        for (int f = 1; f <= 3; f++) begin
            pt = 0; k = 0;
            while (int'(andar_atual) != f && k < 200) begin
                ciclo(4'b0);
                if (passo) pt++;
                k++;
            end
            verifica($sformatf("t2 ticks to floor %0d", f), pt, TV);
        end
        verifica("t2 porta at 3", int'(porta_aberta), 1);
        verifica("t2 pend cleared", int'(pendentes), 0);
        verifica("t2 model floor", m.andar, 3);
        conta_porta("t2 dwell ticks");
        verifica("t2 idle after dwell", int'(em_movimento || porta_aberta), 0);

        // Call at the current floor, then re-press while open.
        ciclo(4'b0100);
        ate_ocioso("t3 reach floor 2", 300);
        verifica("t3 at floor 2", int'(andar_atual), 2);
        ciclo(4'b0100);
        verifica("t3 porta next clock", int'(porta_aberta), 1);
        verifica("t3 pend2 clear", int'(pendentes[2]), 0);
        repeat (5) ciclo(4'b0);
        ciclo(4'b0100);
        verifica("t3 repress pend2", int'(pendentes[2]), 0);
        verifica("t3 repress porta", int'(porta_aberta), 1);
        conta_porta("t3 dwell after repress");

        // passo held low freezes travel but not latching.
        reinicia();
        modo_passo = 0;
        ciclo(4'b1000);
        repeat (100) ciclo(4'b0);
        verifica("t4 andar frozen", int'(andar_atual), 0);
        verifica("t4 moving", int'(em_movimento), 1);
        verifica("t4 pend3", int'(pendentes[3]), 1);

        // Reset mid-travel at floor 2.
        modo_passo = 4; cyc = 0;
        ate_andar("t5 reach floor 2", 2, 200);
        verifica("t5 moving at 2", int'(em_movimento), 1);
        reset_n = 1'b0;
        #1;
        verifica("t5 async andar", int'(andar_atual), 0);
        verifica("t5 async pend", int'(pendentes), 0);
        verifica("t5 async mov", int'(em_movimento), 0);
        verifica("t5 async porta", int'(porta_aberta), 0);
        @(posedge clock_in);
        #1;
        reset_n = 1'b1;

        // SCAN ordering: moving up at floor 1 with calls at 0 and 3.
        portas.delete();
        cyc = 0;
        ciclo(4'b1000);
        ate_andar("t6 reach floor 1", 1, 200);
        ciclo(4'b0001);
        ate_ocioso("t6 all served", 600);
        verifica("t6 doors", portas.size(), 2);
        if (portas.size() == 2) begin
            verifica("t6 first door", portas[0], 3);
            verifica("t6 second door", portas[1], 0);
        end
        verifica("t6 reversed", int'(subindo), 0);

        // Buttons during travel: 2 stops on the way up, 0 waits for the reversal.
        portas.delete();
        ciclo(4'b1000);
        ciclo(4'b0100);
        ciclo(4'b0001);
        ate_ocioso("t7 all served", 800);
        verifica("t7 doors", portas.size(), 3);
        if (portas.size() == 3) begin
            verifica("t7 door a", portas[0], 2);
            verifica("t7 door b", portas[1], 3);
            verifica("t7 door c", portas[2], 0);
        end

        // Random traffic with random passo.
        modo_passo = -1;
        for (int i = 0; i < 4000; i++) begin
            b = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            ciclo(b);
        end
        modo_passo = 2;
        ate_ocioso("random drain", 2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
